// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a START/DATA/STOP
// shift FSM that drives a registered, idle-high tx line.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     tx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CPB   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPB - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push;
  logic             pop;
  logic             bit_done;

  assign bit_done = (clk_cnt == LAST_CNT);
  // push looks at the registered full flag, so a same-cycle pop never frees room
  assign push     = wr_en && !full;
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_done));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count    <= count_next;
      full     <= (count_next == FULL_CNT);
      empty    <= (count_next == '0);
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (pop) begin
            shift   <= mem[rptr];
            clk_cnt <= '0;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            // chain straight into the next start bit when a byte is waiting
            if (pop) begin
              shift <= mem[rptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_FREQ = 16;
  localparam int unsigned BAUD     = 1;
  localparam int unsigned DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx, full, empty, busy, overflow;
  logic [2:0] count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx(tx),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;
  int   busy_total = 0;
  int   busy_falls = 0;
  int   ovf_cnt = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (busy_q === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
    if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    busy_q <= busy;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Finds a start bit (current negedge included), then samples mid-bit.
  task automatic rx_byte(input int limit, output logic [7:0] data, output logic ok, output time t0);
    ok = 1'b0;
    data = 8'h00;
    t0 = 0;
    for (int t = 0; t < limit; t++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    t0 = $time;
    repeat (8) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      data[i] = tx;
    end
    repeat (16) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  logic [7:0] rxd [5];
  logic       ok [5];
  time        ts [5];
  logic [7:0] dummy_d;
  logic       dummy_ok;
  time        dummy_t;
  logic [9:0] line;
  int         hi, bc, b0, f0, o0;

  initial begin
    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, line: 10'b1001111000};
    vecs[4] = '{data: 8'h81, line: 10'b1100000010};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("idle_tx_high_cycles", 32'(hi), 32'd200);

    // single-byte frames from the vector table
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = vecs[r].data;
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("v%0d_count_after_write", r), 32'(count), 32'd1);
      check($sformatf("v%0d_empty_after_write", r), 32'(empty), 32'd0);
      check($sformatf("v%0d_tx_before_start", r), 32'(tx), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_tx_start", r), 32'(tx), 32'd0);
      check($sformatf("v%0d_busy_start", r), 32'(busy), 32'd1);
      check($sformatf("v%0d_count_after_pop", r), 32'(count), 32'd0);
      bc = 0;
      line = '0;
      for (int i = 0; i < 160; i++) begin
        if (busy === 1'b1) bc++;
        if (i % 16 == 8) line[i / 16] = tx;
        @(negedge clk);
      end
      check($sformatf("v%0d_line", r), 32'(line), 32'(vecs[r].line));
      check($sformatf("v%0d_busy_cycles", r), 32'(bc), 32'd160);
      check($sformatf("v%0d_busy_end", r), 32'(busy), 32'd0);
      check($sformatf("v%0d_tx_end", r), 32'(tx), 32'd1);
    end

    // back-to-back frames
    @(negedge clk);
    b0 = busy_total;
    f0 = busy_falls;
    fork
      begin
        wr_en = 1'b1; wr_data = 8'h41;
        @(negedge clk); wr_data = 8'h42;
        @(negedge clk); wr_data = 8'h43;
        @(negedge clk); wr_en = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) rx_byte(50, rxd[j], ok[j], ts[j]);
      end
    join
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b2b_ok%0d", j), 32'(ok[j]), 32'd1);
      check($sformatf("b2b_data%0d", j), 32'(rxd[j]), 32'h41 + 32'(j));
    end
    check("b2b_gap01", 32'(ts[1] - ts[0]), 32'd1600);
    check("b2b_gap12", 32'(ts[2] - ts[1]), 32'd1600);
    for (int t = 0; t < 40; t++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("b2b_busy_total", 32'(busy_total - b0), 32'd480);
    check("b2b_busy_falls", 32'(busy_falls - f0), 32'd1);

    // full / overflow
    @(negedge clk);
    o0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr_en = 1'b1;
          wr_data = 8'(i + 1);
          if (i == 5) begin
            check("ovf_full_before", 32'(full), 32'd1);
            check("ovf_count_full", 32'(count), 32'd4);
          end
          @(negedge clk);
        end
        wr_en = 1'b0;
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count_kept", 32'(count), 32'd4);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 32'd0);
      end
      begin
        for (int j = 0; j < 5; j++) rx_byte(50, rxd[j], ok[j], ts[j]);
      end
    join
    for (int j = 0; j < 5; j++) begin
      check($sformatf("ovf_ok%0d", j), 32'(ok[j]), 32'd1);
      check($sformatf("ovf_data%0d", j), 32'(rxd[j]), 32'(j + 1));
    end
    rx_byte(200, dummy_d, dummy_ok, dummy_t);
    check("ovf_no_sixth_frame", 32'(dummy_ok), 32'd0);
    check("ovf_empty_after", 32'(empty), 32'd1);
    check("ovf_pulse_count", 32'(ovf_cnt - o0), 32'd1);

    // write coinciding with the final stop-cycle pop
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk); wr_data = 8'hC3;
    @(negedge clk); wr_en = 1'b0;
    check("sim_count_queued", 32'(count), 32'd1);
    rx_byte(5, rxd[0], ok[0], ts[0]);
    repeat (7) @(negedge clk);
    check("sim_last_stop_tx", 32'(tx), 32'd1);
    check("sim_last_stop_count", 32'(count), 32'd1);
    wr_en = 1'b1; wr_data = 8'h96;
    @(negedge clk);
    wr_en = 1'b0;
    check("sim_count_unchanged", 32'(count), 32'd1);
    check("sim_next_start_tx", 32'(tx), 32'd0);
    check("sim_busy_kept", 32'(busy), 32'd1);
    rx_byte(5, rxd[1], ok[1], ts[1]);
    rx_byte(50, rxd[2], ok[2], ts[2]);
    check("sim_data0", 32'(rxd[0]), 32'h5A);
    check("sim_data1", 32'(rxd[1]), 32'hC3);
    check("sim_data2", 32'(rxd[2]), 32'h96);
    check("sim_ok", 32'({ok[0], ok[1], ok[2]}), 32'b111);
    check("sim_gap01", 32'(ts[1] - ts[0]), 32'd1600);
    check("sim_gap12", 32'(ts[2] - ts[1]), 32'd1600);
    repeat (10) @(negedge clk);
    check("sim_idle_busy", 32'(busy), 32'd0);

    // reset during data bit 3 of 0xFF with two bytes queued
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge clk); wr_data = 8'h11;
    @(negedge clk); wr_data = 8'h22;
    @(negedge clk); wr_en = 1'b0;
    check("mid_count_queued", 32'(count), 32'd2);
    repeat (69) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_byte(200, dummy_d, dummy_ok, dummy_t);
    check("mid_no_frames_after", 32'(dummy_ok), 32'd0);
    check("mid_count_after", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
